ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have `clk_in`, input, 1 bit: the single clock; every flop is rising-edge on `clk_in`.
REQ-002 SHALL have `rst_in`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have `rdy_in`, input, 1 bit: global pause; while low, all state is frozen.
REQ-004 SHALL have the instruction port:
- `if_req_i` in 1: fetch request.
- `if_addr_i` in 32: fetch address.
- `if_flush_i` in 1: abort fetch.
- `if_done_o` out 1: fetch complete.
- `if_data_o` out 32: fetched word.
REQ-005 SHALL have the data port:
- `ls_req_i` in 1: load/store request.
- `ls_we_i` in 1: 1 = store.
- `ls_addr_i` in 32: access address.
- `ls_size_i` in 2: 0 byte, 1 half, 2 word.
- `ls_wdata_i` in 32: store data.
- `ls_done_o` out 1: access complete.
- `ls_rdata_o` out 32: load data.
REQ-006 SHALL have the RAM port:
- `ram_din_i` in 8: read data.
- `ram_dout_o` out 8: write data.
- `ram_addr_o` out 32: address.
- `ram_wr_o` out 1: 1 = write.
REQ-007 SHALL have `io_buffer_full_i`, input, 1 bit: UART transmit buffer is full.

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, LOAD, STORE with a byte counter `cnt` (0..3) and byte count N: 4 for fetch; 1, 2 or 4 for load/store per `ls_size_i`.
REQ-009 In IDLE, a pending `ls_req_i` SHALL be granted ahead of `if_req_i`; the grant cycle T latches address, size, write data and direction.
REQ-010 A requester's request SHALL be ignored in any cycle its done output is high; requesters hold request and operands stable until done.
REQ-011 FETCH/LOAD: `ram_addr_o` = base+i with `ram_wr_o`=0 in cycle T+1+i; `ram_din_i` in cycle T+2+i is byte i.
REQ-012 Read data SHALL be little-endian: byte i goes to bits 8i+7:8i, and unread upper bytes are 0 (no sign extension).
REQ-013 Read completion: done pulses for exactly one cycle at T+N+2, the data output is valid and held from that cycle until the next completion, and the FSM is in IDLE at T+N+2.
REQ-014 STORE: `ram_addr_o` = base+i, `ram_dout_o` = byte i of `ls_wdata_i`, `ram_wr_o`=1 in cycle T+1+i; `ls_done_o` pulses at T+N+1.
REQ-015 A store byte to an I/O address (`ram_addr_o[17:16]`==2'b11) while `io_buffer_full_i`=1 SHALL hold `ram_wr_o`=0 and `cnt` unchanged until the flag drops; all later timings slip by the stall length.
REQ-016 `if_flush_i`=1 in FETCH SHALL return the FSM to IDLE at the next edge with no `if_done_o` and `if_data_o` unchanged.
REQ-017 `if_flush_i`=1 in IDLE SHALL block a fetch grant that cycle; `if_flush_i` SHALL have no effect on LOAD/STORE.
REQ-018 Byte addresses SHALL be base+i modulo 2^32; no alignment is required.
REQ-019 `rdy_in`=0 SHALL freeze all registers, force `ram_wr_o`=0, and suppress done pulses; operation resumes exactly where it stopped.
REQ-020 In IDLE: `ram_wr_o`=0, `ram_addr_o` holds its last value, `ram_dout_o`=0.

Reset
REQ-021 `rst_in`=0 SHALL asynchronously force: state IDLE, `cnt`=0, all outputs 0 (`if_data_o`, `ls_rdata_o`, both done outputs, `ram_addr_o`, `ram_dout_o`, `ram_wr_o`).
REQ-022 Reset mid-operation SHALL abandon the access with no done pulse; after release, the first grant is possible at the first rising edge.

Structure
REQ-023 SHALL place the state encoding, the size codes (BYTE=0, HALF=1, WORD=2) and the I/O address-match constant (2'b11 on bits 17:16) in the shared constants package.
REQ-024 SHALL use one sub-module, `byte_lane_assembler`, for read byte insertion and write byte selection; the FSM and arbitration stay in `ram_arbiter`.

Verification
REQ-025 Fetch `if_addr_i`=0x100, RAM holds 13 05 00 00 -> `if_done_o` pulses at T+6, `if_data_o`=0x00000513.
REQ-026 `ls_req_i` and `if_req_i` both raised in IDLE, load half at 0x200 (bytes FE FF) -> load served first, `ls_rdata_o`=0x0000FFFE at T+4, fetch granted afterward.
REQ-027 Store byte 0x41 to 0x30000 with `io_buffer_full_i`=1 for 3 cycles -> `ram_wr_o` low for 3 cycles, then one write of 0x41, `ls_done_o` 1 cycle later.
REQ-028 Flush asserted at T+3 of a fetch -> no `if_done_o`, IDLE at T+4, `if_data_o` unchanged.
REQ-029 Word store 0xDEADBEEF to 0xFFFFFFFE with `rdy_in` low for 2 cycles mid-access -> writes EF@0xFFFFFFFE, BE@0xFFFFFFFF, AD@0x0, DE@0x1, no write during pause.
REQ-030 `rst_in` low during LOAD cycle T+2 -> all outputs 0 immediately, no `ls_done_o`, a new load after release completes normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the RAM arbiter: FSM state codes, access size codes,
// the I/O window match and a helper that turns a size code into a last byte index.
package ram_arbiter_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    // Access size codes carried on ls_size_i
    typedef logic [1:0] size_t;
    localparam size_t SIZE_BYTE = 2'd0;
    localparam size_t SIZE_HALF = 2'd1;
    localparam size_t SIZE_WORD = 2'd2;

    // Byte lane index within a 32-bit word
    typedef logic [1:0] byte_idx_t;

    // Addresses whose bits 17:16 equal this value hit the UART transmit buffer
    localparam logic [1:0] IO_ADDR_MATCH = 2'b11;

    // Index of the final byte of an access (byte count minus one).
    // The unused code 3 is treated as a full word.
    function automatic byte_idx_t lastByteIdx(input size_t size);
        case (size)
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            SIZE_WORD: return 2'd3;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ram_arbiter_byte_lane_assembler.sv
// Byte lane steering between the 8-bit RAM and the 32-bit requesters:
// inserts a read byte into its little-endian lane and picks one store byte.
module byte_lane_assembler
    import ram_arbiter_pkg::*;
(
    input  logic [31:0] accWord_i,
    input  logic [7:0]  rdByte_i,
    input  byte_idx_t   rdIdx_i,
    output logic [31:0] accWord_o,
    input  logic [31:0] wrWord_i,
    input  byte_idx_t   wrIdx_i,
    output logic [7:0]  wrByte_o
);

    // Drop the incoming RAM byte into lane rdIdx_i, leaving the other lanes intact
    always_comb begin
        accWord_o = accWord_i;
        case (rdIdx_i)
            2'd0:    accWord_o[7:0]   = rdByte_i;
            2'd1:    accWord_o[15:8]  = rdByte_i;
            2'd2:    accWord_o[23:16] = rdByte_i;
            default: accWord_o[31:24] = rdByte_i;
        endcase
    end

    // Select lane wrIdx_i of the store word for the RAM write bus
    always_comb begin
        case (wrIdx_i)
            2'd0:    wrByte_o = wrWord_i[7:0];
            2'd1:    wrByte_o = wrWord_i[15:8];
            2'd2:    wrByte_o = wrWord_i[23:16];
            default: wrByte_o = wrWord_i[31:24];
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction fetch port and a load/store port onto a single
// byte-wide synchronous RAM. Loads/stores win over fetches; each access is
// split into 1, 2 or 4 sequential byte transfers.
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [1:0]  ls_size_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_done_o,
    output logic [31:0] ls_rdata_o,

    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,

    input  logic        io_buffer_full_i
);

    logic [1:0]  state_q, state_d;
    byte_idx_t   cnt_q, cnt_d;
    byte_idx_t   last_q, last_d;
    logic        first_q, first_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdBuf_q, rdBuf_d;
    logic [31:0] ifData_q, ifData_d;
    logic [31:0] lsData_q, lsData_d;
    logic        ifDone_q, ifDone_d;
    logic        lsDone_q, lsDone_d;

    logic [31:0] asmWord;
    logic [7:0]  storeByte;
    logic        lsGo;
    logic        ifGo;
    logic        ioStall;
    logic        moreToIssue;

    byte_lane_assembler u_lanes (
        .accWord_i (rdBuf_q),
        .rdByte_i  (ram_din_i),
        .rdIdx_i   (cnt_q),
        .accWord_o (asmWord),
        .wrWord_i  (wdata_q),
        .wrIdx_i   (cnt_q),
        .wrByte_o  (storeByte)
    );

    // A requester whose done is currently high has just been served, so its
    // still-raised request must not start a second access. A flush also vetoes
    // starting a fetch.
    assign lsGo    = ls_req_i & ~lsDone_q;
    assign ifGo    = if_req_i & ~ifDone_q & ~if_flush_i;

    // A store byte aimed at the UART window waits while its buffer is full
    assign ioStall = (addr_q[17:16] == IO_ADDR_MATCH) & io_buffer_full_i;

    // During a read the address runs one byte ahead of the captured byte
    assign moreToIssue = ({1'b0, cnt_q} + 3'd2) <= {1'b0, last_q};

    // Next-state logic: grant, byte sequencing, read assembly and completion
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        first_d  = first_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdBuf_d  = rdBuf_q;
        ifData_d = ifData_q;
        lsData_d = lsData_q;
        ifDone_d = 1'b0;
        lsDone_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdBuf_d = 32'd0;
                cnt_d   = 2'd0;
                if (lsGo) begin
                    state_d = ls_we_i ? ST_STORE : ST_LOAD;
                    addr_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    last_d  = lastByteIdx(ls_size_i);
                    first_d = 1'b1;
                end else if (ifGo) begin
                    state_d = ST_FETCH;
                    addr_d  = if_addr_i;
                    last_d  = 2'd3;
                    first_d = 1'b1;
                end
            end

            ST_FETCH, ST_LOAD: begin
                if ((state_q == ST_FETCH) && if_flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else if (first_q) begin
                    first_d = 1'b0;
                    if (last_q != 2'd0) begin
                        addr_d = addr_q + 32'd1;
                    end
                end else begin
                    rdBuf_d = asmWord;
                    if (cnt_q == last_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = 2'd0;
                        if (state_q == ST_FETCH) begin
                            ifData_d = asmWord;
                            ifDone_d = 1'b1;
                        end else begin
                            lsData_d = asmWord;
                            lsDone_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        if (moreToIssue) begin
                            addr_d = addr_q + 32'd1;
                        end
                    end
                end
            end

            default: begin
                if (!ioStall) begin
                    if (cnt_q == last_q) begin
                        state_d  = ST_IDLE;
                        cnt_d    = 2'd0;
                        lsDone_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + 2'd1;
                        addr_d = addr_q + 32'd1;
                    end
                end
            end
        endcase
    end

    // State registers; a low rdy_in freezes everything in place
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            last_q   <= 2'd0;
            first_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdBuf_q  <= 32'd0;
            ifData_q <= 32'd0;
            lsData_q <= 32'd0;
            ifDone_q <= 1'b0;
            lsDone_q <= 1'b0;
        end else if (rdy_in) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdBuf_q  <= rdBuf_d;
            ifData_q <= ifData_d;
            lsData_q <= lsData_d;
            ifDone_q <= ifDone_d;
            lsDone_q <= lsDone_d;
        end
    end

    // Done pulses are hidden while paused and reappear when operation resumes
    assign if_done_o  = ifDone_q & rdy_in;
    assign ls_done_o  = lsDone_q & rdy_in;
    assign if_data_o  = ifData_q;
    assign ls_rdata_o = lsData_q;

    assign ram_addr_o = addr_q;
    assign ram_dout_o = (state_q == ST_STORE) ? storeByte : 8'd0;
    assign ram_wr_o   = (state_q == ST_STORE) & ~ioStall & rdy_in;

endmodule
